// File: rtl/stacker_popcount_bist_if.sv
// rtl/stacker_popcount_bist_if.sv - functional, result and BIST signal bundle for the bit stacker
interface stacker_popcount_bist_if #(
    parameter int N = 6
);
    localparam int CW = $clog2(N + 1);

    logic          mode;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic [N-1:0]  out_stack;
    logic [CW-1:0] out_count;
    logic          bist_start;
    logic          fault_inj;
    logic          bist_busy;
    logic          bist_done;
    logic          bist_pass;
    logic [7:0]    bist_err_cnt;

    modport master (
        output mode, in_valid, in_data, bist_start, fault_inj,
        input  out_valid, out_stack, out_count, bist_busy, bist_done, bist_pass, bist_err_cnt
    );

    modport slave (
        input  mode, in_valid, in_data, bist_start, fault_inj,
        output out_valid, out_stack, out_count, bist_busy, bist_done, bist_pass, bist_err_cnt
    );
endinterface

// File: rtl/stacker_popcount_bist.sv
// rtl/stacker_popcount_bist.sv - two-stage bit stacker with popcount and LFSR self-test
module stacker_popcount_bist #(
    parameter int          N        = 6,
    parameter int          NUM_VECT = 64,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    stacker_popcount_bist_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] LAST_VECT = 16'(NUM_VECT - 1);

    logic [1:0]    state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   vec_cnt_q, vec_cnt_d;
    logic          drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          clr_err;

    logic          valid1_q, valid1_d;
    logic [N-1:0]  vec1_q, vec1_d;
    logic          valid2_q, valid2_d;
    logic [N-1:0]  stack2_q, stack2_d;
    logic [CW-1:0] count2_q, count2_d;
    logic [CW-1:0] ref2_q, ref2_d;

    logic          src_valid;
    logic [N-1:0]  src_data;
    logic [N-1:0]  sorted;
    logic [CW-1:0] ref_cnt;
    logic [CW-1:0] derived_cnt;
    logic [15:0]   lfsr_next;
    logic          thermo_bad;
    logic          vec_err;
    logic          chk_en;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
    always_comb begin
        lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // BIST sequencing: vector issue, pipeline drain, result hold and abort on mode drop
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        vec_cnt_d = vec_cnt_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        clr_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mode && bus.bist_start) begin
                    state_d   = S_RUN;
                    lfsr_d    = SEED;
                    vec_cnt_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    clr_err   = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.mode) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    lfsr_d    = lfsr_next;
                    vec_cnt_d = vec_cnt_q + 16'd1;
                    if (vec_cnt_q == LAST_VECT) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.mode) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (drain_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                if (!bus.mode) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (bus.bist_start) begin
                    state_d   = S_RUN;
                    lfsr_d    = SEED;
                    vec_cnt_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    clr_err   = 1'b1;
                end else begin
                    // err_cnt is final by now, so done and pass rise together
                    done_d = 1'b1;
                    pass_d = (err_cnt_q == 8'd0);
                end
            end
        endcase
    end

    // Stage 1 source select: functional port or LFSR vector while running
    always_comb begin
        src_valid = bus.mode ? (state_q == S_RUN) : bus.in_valid;
        src_data  = bus.mode ? lfsr_q[N-1:0] : bus.in_data;
        valid1_d  = src_valid;
        vec1_d    = src_valid ? src_data : vec1_q;
    end

    // Odd-even transposition network: ones collect at the low end
    always_comb begin
        sorted = vec1_q;
        for (int p = 0; p < N; p++) begin
            for (int i = 0; i < N - 1; i++) begin
                if ((i % 2) == (p % 2)) begin
                    {sorted[i+1], sorted[i]} = {sorted[i] & sorted[i+1], sorted[i] | sorted[i+1]};
                end
            end
        end
    end

    // Reference popcount, independent of the sorting network
    always_comb begin
        ref_cnt = '0;
        for (int i = 0; i < N; i++) begin
            ref_cnt = ref_cnt + CW'(vec1_q[i]);
        end
    end

    // Stage 2 next values; count comes from the highest set thermometer bit
    always_comb begin
        valid2_d    = valid1_q;
        stack2_d    = stack2_q;
        count2_d    = count2_q;
        ref2_d      = ref2_q;
        derived_cnt = '0;
        if (valid1_q) begin
            stack2_d = sorted ^ {{(N-1){1'b0}}, bus.fault_inj};
            for (int k = 0; k < N; k++) begin
                if (stack2_d[k]) begin
                    derived_cnt = CW'(k + 1);
                end
            end
            count2_d = derived_cnt;
            ref2_d   = ref_cnt;
        end
    end

    // Result checker on the registered stage-2 values
    always_comb begin
        thermo_bad = 1'b0;
        for (int k = 1; k < N; k++) begin
            if (stack2_q[k] && !stack2_q[k-1]) begin
                thermo_bad = 1'b1;
            end
        end
        vec_err   = thermo_bad || (count2_q != ref2_q);
        chk_en    = valid2_q && ((state_q == S_RUN) || (state_q == S_DRAIN));
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = 8'd0;
        end else if (chk_en && vec_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            vec_cnt_q <= '0;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 8'd0;
            valid1_q  <= 1'b0;
            vec1_q    <= '0;
            valid2_q  <= 1'b0;
            stack2_q  <= '0;
            count2_q  <= '0;
            ref2_q    <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            vec_cnt_q <= vec_cnt_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            valid1_q  <= valid1_d;
            vec1_q    <= vec1_d;
            valid2_q  <= valid2_d;
            stack2_q  <= stack2_d;
            count2_q  <= count2_d;
            ref2_q    <= ref2_d;
        end
    end

    assign bus.out_valid    = valid2_q;
    assign bus.out_stack    = stack2_q;
    assign bus.out_count    = count2_q;
    assign bus.bist_busy    = busy_q;
    assign bus.bist_done    = done_q;
    assign bus.bist_pass    = pass_q;
    assign bus.bist_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_stacker_popcount_bist.sv
// tb/tb_stacker_popcount_bist.sv - directed bench for stacker_popcount_bist
module tb_stacker_popcount_bist;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    stacker_popcount_bist_if #(.N(6)) ifa ();
    stacker_popcount_bist_if #(.N(6)) ifb ();

    stacker_popcount_bist #(.N(6), .NUM_VECT(64), .SEED(16'hACE1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    stacker_popcount_bist #(.N(6), .NUM_VECT(300), .SEED(16'hACE1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] d;
        logic       ev;
        logic [5:0] es;
        int         ec;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_out_valid"}, ifa.out_valid, 0);
        chk({tag, "_out_stack"}, ifa.out_stack, 0);
        chk({tag, "_out_count"}, ifa.out_count, 0);
        chk({tag, "_busy"}, ifa.bist_busy, 0);
        chk({tag, "_done"}, ifa.bist_done, 0);
        chk({tag, "_pass"}, ifa.bist_pass, 0);
        chk({tag, "_err_cnt"}, ifa.bist_err_cnt, 0);
    endtask

    // Start a run on dut_a and check busy/done cycle by cycle; extra_k re-pulses start mid-run
    task automatic run_a(input string tag, input int extra_k, input int exp_pass, input int exp_err);
        ifa.bist_start = 1'b1;
        step();
        ifa.bist_start = 1'b0;
        chk({tag, "_busy_k0"}, ifa.bist_busy, 1);
        for (int k = 1; k <= 67; k++) begin
            ifa.bist_start = (k == extra_k);
            step();
            ifa.bist_start = 1'b0;
            chk($sformatf("%s_busy_k%0d", tag, k), ifa.bist_busy, (k < 66) ? 1 : 0);
            chk($sformatf("%s_done_k%0d", tag, k), ifa.bist_done, (k >= 67) ? 1 : 0);
        end
        chk({tag, "_pass"}, ifa.bist_pass, exp_pass);
        chk({tag, "_err_cnt"}, ifa.bist_err_cnt, exp_err);
    endtask

    initial begin
        int kb;
        total = 0;
        bad   = 0;

        tbl[0] = '{1'b1, 6'b101101, 1'b1, 6'b001111, 4};
        tbl[1] = '{1'b1, 6'b000000, 1'b1, 6'b000000, 0};
        tbl[2] = '{1'b1, 6'b111111, 1'b1, 6'b111111, 6};
        tbl[3] = '{1'b1, 6'b000001, 1'b1, 6'b000001, 1};
        tbl[4] = '{1'b0, 6'b111111, 1'b0, 6'b000001, 1};
        tbl[5] = '{1'b1, 6'b110000, 1'b1, 6'b000011, 2};
        tbl[6] = '{1'b1, 6'b010101, 1'b1, 6'b000111, 3};
        tbl[7] = '{1'b1, 6'b011111, 1'b1, 6'b011111, 5};

        rst            = 1'b1;
        ifa.mode       = 1'b0;
        ifa.in_valid   = 1'b0;
        ifa.in_data    = '0;
        ifa.bist_start = 1'b0;
        ifa.fault_inj  = 1'b0;
        ifb.mode       = 1'b0;
        ifb.in_valid   = 1'b0;
        ifb.in_data    = '0;
        ifb.bist_start = 1'b0;
        ifb.fault_inj  = 1'b0;
        repeat (3) step();
        chk_zero_a("reset");
        rst = 1'b0;
        step();

        // Functional vectors: result of entry i appears after the second edge
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                ifa.in_valid = tbl[i].v;
                ifa.in_data  = tbl[i].d;
            end else begin
                ifa.in_valid = 1'b0;
                ifa.in_data  = '0;
            end
            step();
            if (i >= 1) begin
                chk($sformatf("vec%0d_valid", i - 1), ifa.out_valid, tbl[i-1].ev);
                chk($sformatf("vec%0d_stack", i - 1), ifa.out_stack, tbl[i-1].es);
                chk($sformatf("vec%0d_count", i - 1), ifa.out_count, tbl[i-1].ec);
            end
        end
        step();
        chk("idle_valid", ifa.out_valid, 0);
        chk("idle_hold_stack", ifa.out_stack, 6'b011111);

        ifa.mode = 1'b1;
        step();
        run_a("bist1", -1, 1, 0);
        run_a("bist2", -1, 1, 0);
        run_a("start_in_run", 5, 1, 0);

        ifa.fault_inj = 1'b1;
        run_a("fault", -1, 0, 64);
        ifa.fault_inj = 1'b0;

        ifa.mode = 1'b0;
        step();
        chk("done_to_idle_done", ifa.bist_done, 0);
        chk("done_to_idle_pass", ifa.bist_pass, 0);

        // Abort by dropping mode at RUN cycle 10
        ifa.mode = 1'b1;
        step();
        ifa.bist_start = 1'b1;
        step();
        ifa.bist_start = 1'b0;
        repeat (10) step();
        ifa.mode = 1'b0;
        step();
        chk("abort_busy", ifa.bist_busy, 0);
        chk("abort_done", ifa.bist_done, 0);
        chk("abort_err", ifa.bist_err_cnt, 0);
        repeat (70) step();
        chk("abort_done_later", ifa.bist_done, 0);

        // Reset in the middle of a run, then a clean run
        ifa.mode = 1'b1;
        step();
        ifa.bist_start = 1'b1;
        step();
        ifa.bist_start = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        chk_zero_a("midrst");
        rst = 1'b0;
        step();
        run_a("after_rst", -1, 1, 0);

        // Saturating error count on the 300-vector instance
        ifb.mode      = 1'b1;
        ifb.fault_inj = 1'b1;
        step();
        ifb.bist_start = 1'b1;
        step();
        ifb.bist_start = 1'b0;
        kb = 0;
        while (!ifb.bist_done && kb < 400) begin
            step();
            kb++;
        end
        chk("sat_done_latency", kb, 303);
        chk("sat_err_cnt", ifb.bist_err_cnt, 255);
        chk("sat_pass", ifb.bist_pass, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stacker_popcount_bist.md
Name: stacker_popcount_bist

Overview:
- Parametrised, pipelined N-input bit stacker for the fast counter datapath.
- Sorts N input bits into a thermometer vector and emits the binary population count.
- Built-in self-test mode drives LFSR patterns through the same pipeline and checks every result against an independent popcount.
- Reports pass/fail and an error count.

Parameters:
- N, 6, number of input bits (2..16).
- CW, $clog2(N+1), count width (derived, not overridden).
- NUM_VECT, 64, BIST vectors per run (1..65535).
- SEED, 16'hACE1, LFSR seed (must be nonzero).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- mode  in  1  0 = functional, 1 = BIST.
- in_valid  in  1  functional input qualifier.
- in_data  in  N  functional input bits.
- out_valid  out  1  result qualifier.
- out_stack  out  N  thermometer output; bit k = 1 iff popcount > k.
- out_count  out  CW  binary popcount.
- bist_start  in  1  single-cycle start request.
- fault_inj  in  1  test hook; XORs stage-2 stack bit 0, affects outputs and the checker.
- bist_busy  out  1  BIST run in progress.
- bist_done  out  1  run complete (level).
- bist_pass  out  1  valid when bist_done; 1 iff bist_err_cnt == 0.
- bist_err_cnt  out  8  mismatching vectors, saturates at 255.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, LFSR = SEED, pipeline valids cleared. Reset mid-run aborts the run with no done/pass.
- Pipeline latency is 2 cycles, throughput 1 per cycle.
  - Stage 1 registers the selected vector and its valid.
  - Stage 2 registers the sorted thermometer, the count derived from the thermometer, and a reference popcount from a separate adder tree.
- Source mux: mode 0 uses in_data/in_valid; mode 1 uses lfsr[N-1:0] with valid = (state == RUN). in_valid is ignored in mode 1.
- out_valid, out_stack and out_count are driven in both modes. Outputs hold their last value when out_valid = 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per RUN cycle only. Reloaded to SEED on entry to RUN.
- FSM:
  - IDLE: mode=1 and bist_start=1 → RUN. Clears err_cnt, done and pass; sets busy.
  - RUN: issues one vector per cycle. After NUM_VECT vectors → DRAIN.
  - DRAIN: 2 cycles to empty the pipeline → DONE.
  - DONE: done=1, pass=(err_cnt==0), busy=0. bist_start with mode=1 → RUN. mode=0 → IDLE with done cleared.
- bist_start is ignored in RUN, in DRAIN, and whenever mode=0.
- mode dropping to 0 in RUN or DRAIN aborts to IDLE: busy=0, done=0, err_cnt held.
- bist_done rises NUM_VECT+3 cycles after the edge that sampled bist_start.
- Checker, active only on stage-2 valid during RUN or DRAIN. A vector is an error if either holds:
  - out_stack is not a thermometer, i.e. some bit k=1 with bit k-1=0.
  - The thermometer-derived count ≠ the reference popcount.
- err_cnt increments by 1 per erroneous vector and saturates at 255.
- fault_inj applies on any cycle. Flipping bit 0 always produces a checker error.
- Width rules: counts are zero-extended to CW. out_count = N is representable for all N.

Test Plan:
- N=6, mode=0, in_data=6'b101101 with in_valid pulse at cycle t → at t+2: out_valid=1, out_stack=6'b001111, out_count=4.
- Back-to-back 6'b000000, 6'b111111, 6'b000001 → on consecutive cycles: stack 000000/111111/000001, count 0/6/1. in_valid gap gives out_valid=0.
- BIST with NUM_VECT=64, fault_inj=0 → busy for 66 cycles, then done=1 at start+67, pass=1, err_cnt=0. A second bist_start from DONE repeats the result identically.
- BIST with fault_inj=1 for the whole run → done=1, pass=0, err_cnt=64. With NUM_VECT=300 → err_cnt saturates at 255.
- bist_start during RUN → ignored, and done timing is unchanged. mode→0 at RUN cycle 10 → IDLE, done=0, busy=0.
- rst asserted mid-RUN → next cycle all outputs 0. Fresh start then gives the same pass result and err_cnt=0.
